// File: rtl/sram_seq_ctrl.sv
// Single-word SRAM access sequencer: precharge, wordline and sense phases per request.
// All array-facing and handshake outputs are registered in one state machine.
module sram_seq_ctrl #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRE_CYC = 1,
    parameter int unsigned WL_CYC  = 2,
    parameter int unsigned SAE_CYC = 1,
    localparam int unsigned ROWS   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              cs,
    output logic              w_en,
    output logic [DATA_W-1:0] col_data,
    output logic              pre_n,
    output logic [ROWS-1:0]   wl,
    output logic              sae,
    input  logic [DATA_W-1:0] sa_data
);

    typedef enum logic [2:0] {IDLE, PRE, ACT, SENSE, DONE} state_t;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);
    localparam logic [3:0] SAE_LOAD = 4'(SAE_CYC - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    // NOTE: every register here is assigned with <= so all of them update from the
    // same pre-edge values; a blocking '=' would let later lines see half-updated state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            cs         <= 1'b0;
            w_en       <= 1'b0;
            col_data   <= '0;
            pre_n      <= 1'b1;
            wl         <= '0;
            sae        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        state     <= PRE;
                        cnt       <= PRE_LOAD;
                        req_ready <= 1'b0;
                        pre_n     <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt == 4'd0) begin
                        state    <= ACT;
                        cnt      <= WL_LOAD;
                        pre_n    <= 1'b1;
                        wl       <= ROWS'(1) << addr_q;
                        cs       <= 1'b1;
                        w_en     <= we_q;
                        col_data <= we_q ? wdata_q : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACT: begin
                    if (cnt == 4'd0) begin
                        if (we_q) begin
                            state      <= DONE;
                            wl         <= '0;
                            cs         <= 1'b0;
                            w_en       <= 1'b0;
                            col_data   <= '0;
                            resp_valid <= 1'b1;
                        end else begin
                            // Wordline stays up while the sense amps resolve.
                            state <= SENSE;
                            cnt   <= SAE_LOAD;
                            sae   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SENSE: begin
                    if (cnt == 4'd0) begin
                        state      <= DONE;
                        resp_rdata <= sa_data;
                        wl         <= '0;
                        cs         <= 1'b0;
                        sae        <= 1'b0;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Self-checking bench for sram_seq_ctrl: directed phase traces, random traffic against a
// word-level memory model, reset mid-operation and a non-default timing configuration.
module tb_sram_seq_ctrl;

    localparam int ROWS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, resp_valid, cs, w_en, pre_n, sae;
    logic [7:0] resp_rdata, col_data, sa_data;
    logic [7:0] wl;

    logic       r2_valid = 1'b0, r2_we = 1'b0;
    logic [2:0] r2_addr = '0;
    logic [7:0] r2_wdata = '0;
    logic [7:0] r2_sa = 8'hC3;
    logic       r2_ready, r2_resp_valid, r2_cs, r2_w_en, r2_pre_n, r2_sae;
    logic [7:0] r2_rdata, r2_col, r2_wl;

    sram_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .cs(cs), .w_en(w_en),
        .col_data(col_data), .pre_n(pre_n), .wl(wl), .sae(sae), .sa_data(sa_data)
    );

    sram_seq_ctrl #(.PRE_CYC(3), .WL_CYC(1), .SAE_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready),
        .req_we(r2_we), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .resp_valid(r2_resp_valid), .resp_rdata(r2_rdata), .cs(r2_cs), .w_en(r2_w_en),
        .col_data(r2_col), .pre_n(r2_pre_n), .wl(r2_wl), .sae(r2_sae), .sa_data(r2_sa)
    );

    // Bitline-level array: written through the column driver, read via the active wordline.
    logic [7:0] env_mem [ROWS] = '{default: 8'h00};
    logic       sa_ovr_en = 1'b0;
    logic [7:0] sa_ovr = '0;

    always @(posedge clk)
        if (cs && w_en)
            for (int i = 0; i < ROWS; i++)
                if (wl[i]) env_mem[i] <= col_data;

    always_comb begin
        sa_data = '0;
        for (int i = 0; i < ROWS; i++)
            if (wl[i]) sa_data = env_mem[i];
        if (sa_ovr_en) sa_data = sa_ovr;
    end

    // Word-level reference: what each row holds and what the last read returned.
    logic [7:0] exp_mem [ROWS] = '{default: 8'h00};
    logic [7:0] last_read = '0;

    int tests = 0;
    int failed = 0;
    logic mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("inv_wl_onehot", 32'($onehot0(wl)), 32'd1);
            check("inv_wl_vs_pre", 32'(wl != 8'h00 && !pre_n), 32'd0);
            check("inv_sae_rule", 32'(sae && !(wl != 8'h00 && !w_en)), 32'd0);
            check("inv_cs_vs_pre", 32'(!pre_n && cs), 32'd0);
        end
    end

    task automatic do_req(input logic we, input logic [2:0] a, input logic [7:0] d);
        int waited = 0;
        int lat = -1;
        int exp_lat;
        logic [7:0] exp_rd;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        exp_lat = we ? (1 + 2 + 1) : (1 + 2 + 1 + 1);
        if (we) begin
            exp_mem[a] = d;
            exp_rd = last_read;
        end else begin
            exp_rd = exp_mem[a];
            last_read = exp_rd;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        // Scrambled inputs while busy must be ignored.
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = 3'($urandom); req_wdata = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        check("rand_latency", 32'(lat), 32'(exp_lat));
        check("rand_rdata", 32'(resp_rdata), 32'(exp_rd));
        tick();
        check("rand_pulse_width", 32'(resp_valid), 32'd0);
        check("rand_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int p1, p2, acc2, npulse;
        logic [7:0] rd1, rd2;

        tick();
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_pre_n", 32'(pre_n), 32'd1);
        check("rst_wl", 32'(wl), 32'd0);
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_sae", 32'(sae), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", 32'(resp_rdata), 32'd0);

        // Directed write, addr 5 <- A5.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0; req_wdata = 8'hFF;
        check("wr_c1_pre_n", 32'(pre_n), 32'd0);
        check("wr_c1_cs", 32'(cs), 32'd0);
        check("wr_c1_ready", 32'(req_ready), 32'd0);
        tick();
        check("wr_c2_wl", 32'(wl), 32'h20);
        check("wr_c2_cs", 32'(cs), 32'd1);
        check("wr_c2_w_en", 32'(w_en), 32'd1);
        check("wr_c2_col", 32'(col_data), 32'hA5);
        tick();
        check("wr_c3_wl", 32'(wl), 32'h20);
        check("wr_c3_col", 32'(col_data), 32'hA5);
        tick();
        check("wr_c4_resp", 32'(resp_valid), 32'd1);
        check("wr_c4_wl", 32'(wl), 32'd0);
        tick();
        check("wr_c5_ready", 32'(req_ready), 32'd1);
        check("wr_c5_resp", 32'(resp_valid), 32'd0);
        exp_mem[5] = 8'hA5;

        // Directed read, addr 2, sense amps forced to 3C.
        sa_ovr_en = 1'b1; sa_ovr = 8'h3C;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
        tick();
        req_valid = 1'b0;
        check("rd_c1_pre_n", 32'(pre_n), 32'd0);
        tick();
        check("rd_c2_wl", 32'(wl), 32'h04);
        check("rd_c2_w_en", 32'(w_en), 32'd0);
        check("rd_c2_col", 32'(col_data), 32'd0);
        tick();
        check("rd_c3_wl", 32'(wl), 32'h04);
        check("rd_c3_sae", 32'(sae), 32'd0);
        tick();
        check("rd_c4_sae", 32'(sae), 32'd1);
        check("rd_c4_wl", 32'(wl), 32'h04);
        tick();
        check("rd_c5_resp", 32'(resp_valid), 32'd1);
        check("rd_c5_rdata", 32'(resp_rdata), 32'h3C);
        tick();
        check("rd_c6_ready", 32'(req_ready), 32'd1);
        sa_ovr_en = 1'b0;
        last_read = 8'h3C;

        // A write must leave the last read word in place.
        do_req(1'b1, 3'd1, 8'h77);
        check("wr_keeps_rdata", 32'(resp_rdata), 32'h3C);

        // Two reads with req_valid held high.
        rd1 = exp_mem[3];
        rd2 = exp_mem[6];
        p1 = 0; p2 = 0; acc2 = 0; npulse = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        tick();
        req_addr = 3'd6;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid) begin
                npulse++;
                if (npulse == 1) begin
                    p1 = c;
                    check("b2b_rdata1", 32'(resp_rdata), 32'(rd1));
                end else begin
                    p2 = c;
                    check("b2b_rdata2", 32'(resp_rdata), 32'(rd2));
                end
            end
            if (req_valid && req_ready) acc2 = c;
            tick();
            if (acc2 == c) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        last_read = rd2;
        check("b2b_pulses", 32'(npulse), 32'd2);
        check("b2b_first_resp", 32'(p1), 32'd5);
        check("b2b_second_accept", 32'(acc2), 32'd6);
        check("b2b_gap", 32'(p2 - p1), 32'd6);

        // Random traffic against the word-level model.
        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom), 3'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the middle of a write's wordline phase.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd4; req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_c2_wl", 32'(wl), 32'h10);
        rst_n = 1'b0;
        tick();
        check("mid_rst_wl", 32'(wl), 32'd0);
        check("mid_rst_cs", 32'(cs), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", 32'(resp_rdata), 32'd0);
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) npulse++;
            tick();
        end
        check("mid_no_resp", 32'(npulse), 32'd0);
        check("mid_idle_ready", 32'(req_ready), 32'd1);

        // PRE_CYC=3, WL_CYC=1, SAE_CYC=2 read trace.
        r2_valid = 1'b1; r2_we = 1'b0; r2_addr = 3'd6;
        tick();
        r2_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("p2_pre_n", 32'(r2_pre_n), 32'(!(c <= 3)));
            check("p2_wl", 32'(r2_wl), 32'((c >= 4 && c <= 6) ? 8'h40 : 8'h00));
            check("p2_sae", 32'(r2_sae), 32'(c == 5 || c == 6));
            check("p2_resp", 32'(r2_resp_valid), 32'(c == 7));
            check("p2_ready", 32'(r2_ready), 32'(c == 8));
            if (c == 7) check("p2_rdata", 32'(r2_rdata), 32'hC3);
            tick();
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
